// File: rtl/weight_addr_seq.sv
// Skewed weight-ROM address sequencer: lane 0 walks base..base+len-1, (rep+1) times,
// and every further lane replays the lane before it one advancing cycle later.
module weight_addr_seq #(
    parameter int NUM_CH = 6,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8,
    parameter int REP_W  = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic [ADDR_W-1:0]        i_base,
    input  logic [LEN_W-1:0]         i_len,
    input  logic [REP_W-1:0]         i_rep,
    input  logic                     i_stall,
    input  logic                     i_flush,
    output logic [NUM_CH-1:0]        o_ch_en,
    output logic [NUM_CH*ADDR_W-1:0] o_addr,
    output logic                     o_data_en,
    output logic                     o_busy,
    output logic                     o_done
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [REP_W-1:0]   rcnt_q, rcnt_d;
    logic               done_q, done_d;
    logic [NUM_CH-1:0]  en_q, en_d;
    logic [ADDR_W-1:0]  addr_q [NUM_CH];
    logic [ADDR_W-1:0]  addr_d [NUM_CH];

    logic               start_ok;
    logic               emit;
    logic               lane0_en;
    logic [ADDR_W-1:0]  cur_base;
    logic [LEN_W-1:0]   cur_len;
    logic [REP_W-1:0]   cur_rep;
    logic [LEN_W-1:0]   cur_cnt;
    logic [REP_W-1:0]   cur_rcnt;
    logic [ADDR_W-1:0]  cnt_ext;
    logic [ADDR_W-1:0]  lane0_addr;

    // A start in the o_done cycle is ignored so back-to-back requests see a clean IDLE.
    assign start_ok = (state_q == ST_IDLE) && i_start && !done_q;

    // The accepting edge already emits word 0, so the start path feeds the same
    // counter-advance logic as RUN with fresh operands.
    always_comb begin
        cur_base = base_q;
        cur_len  = len_q;
        cur_rep  = rep_q;
        cur_cnt  = cnt_q;
        cur_rcnt = rcnt_q;
        emit     = 1'b0;
        if (!i_flush && !i_stall) begin
            if (state_q == ST_RUN) begin
                emit = 1'b1;
            end else if (start_ok && (i_len != '0)) begin
                emit     = 1'b1;
                cur_base = i_base;
                cur_len  = i_len;
                cur_rep  = i_rep;
                cur_cnt  = '0;
                cur_rcnt = '0;
            end
        end
    end

    generate
        if (LEN_W >= ADDR_W) begin : g_cnt_trunc
            assign cnt_ext = cur_cnt[ADDR_W-1:0];
        end else begin : g_cnt_zext
            assign cnt_ext = {{(ADDR_W-LEN_W){1'b0}}, cur_cnt};
        end
    endgenerate

    assign lane0_addr = cur_base + cnt_ext;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        rep_d    = rep_q;
        cnt_d    = cnt_q;
        rcnt_d   = rcnt_q;
        done_d   = 1'b0;
        en_d     = en_q;
        addr_d   = addr_q;
        lane0_en = 1'b0;
        if (i_flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            rcnt_d  = '0;
            en_d    = '0;
        end else if (!i_stall) begin
            if (emit) begin
                lane0_en = 1'b1;
                base_d   = cur_base;
                len_d    = cur_len;
                rep_d    = cur_rep;
                if (cur_cnt == cur_len - LEN_ONE) begin
                    cnt_d = '0;
                    if (cur_rcnt == cur_rep) begin
                        state_d = ST_DRAIN;
                        rcnt_d  = '0;
                    end else begin
                        state_d = ST_RUN;
                        rcnt_d  = cur_rcnt + REP_ONE;
                    end
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = cur_cnt + LEN_ONE;
                    rcnt_d  = cur_rcnt;
                end
            end else if (start_ok) begin
                done_d = 1'b1;
            end else if ((state_q == ST_DRAIN) && (en_q[NUM_CH-2:0] == '0)) begin
                // Lanes 0..NUM_CH-2 are empty, so this edge also empties the last lane.
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            en_d      = {en_q[NUM_CH-2:0], lane0_en};
            addr_d[0] = emit ? lane0_addr : addr_q[0];
            for (int k = 1; k < NUM_CH; k++) begin
                addr_d[k] = addr_q[k-1];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            rep_q   <= '0;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            done_q  <= 1'b0;
            en_q    <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                addr_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            done_q  <= done_d;
            en_q    <= en_d;
            for (int k = 0; k < NUM_CH; k++) begin
                addr_q[k] <= addr_d[k];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane_out
            assign o_addr[gi*ADDR_W +: ADDR_W] = addr_q[gi];
        end
    endgenerate

    assign o_ch_en   = en_q;
    assign o_data_en = |en_q;
    assign o_busy    = (state_q != ST_IDLE);
    assign o_done    = done_q;

endmodule
